// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin arbiter:
// state encoding, default sizing and a small index helper.
package mux2_rr_arbiter_pkg;

  // Default data width and burst limit of the shared channel
  localparam int DEFAULT_W         = 4;
  localparam int DEFAULT_MAX_BURST = 4;

  // Beat counter width; bounds the legal burst limit to 1..15
  localparam int COUNT_W = 4;

  // Arbiter states; the unused code 2'd3 recovers to idle
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT0  = 2'd1,
    ST_GRANT1  = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  // Maps a requester index onto its grant state
  function automatic state_e grantState(input logic idx);
    return idx ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux.sv
// W-bit 2:1 data mux that steers the granted requester's beat
// towards the output register.
module mux_2to1_4b #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  // Pick requester 1 data when the select is high, requester 0 otherwise
  always_comb begin
    y_o = sel_i ? b_i : a_i;
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one registered W-bit output channel between
// two valid/ready requesters. A grant is held for up to MAX_BURST beats,
// or until the granted requester goes idle, then priority rotates.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int W         = DEFAULT_W,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in0_valid,
  input  logic [W-1:0] in0_data,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic [W-1:0] in1_data,
  output logic         in1_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_src,
  input  logic         out_ready,
  output logic         sel,
  output logic         busy
);

  localparam logic [COUNT_W-1:0] BURST_LIMIT = COUNT_W'(MAX_BURST);

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               outValid_q;
  logic [W-1:0]       outData_q;
  logic               outSrc_q;

  logic               grantIdx;
  logic               inGrant;
  logic               grantValid;
  logic               otherValid;
  logic               canLoad;
  logic               xfer;
  logic               burstEnd;
  logic               grantDone;
  logic [COUNT_W-1:0] countInc;
  logic [W-1:0]       muxData;

  mux_2to1_4b #(
    .W (W)
  ) u_mux (
    .a_i   (in0_data),
    .b_i   (in1_data),
    .sel_i (grantIdx),
    .y_o   (muxData)
  );

  // Decode the current grant and decide whether a beat moves this cycle
  always_comb begin
    inGrant    = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
    grantIdx   = (state_q == ST_GRANT1);
    grantValid = grantIdx ? in1_valid : in0_valid;
    otherValid = grantIdx ? in0_valid : in1_valid;
    canLoad    = !outValid_q || out_ready;
    xfer       = inGrant && grantValid && canLoad;
    countInc   = count_q + COUNT_W'(1);
    burstEnd   = xfer && (countInc == BURST_LIMIT);
    grantDone  = inGrant && (!grantValid || burstEnd);
  end

  // Next grant, priority pointer and beat count
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (in0_valid && in1_valid) begin
          state_d = grantState(!last_q);
        end else if (in0_valid) begin
          state_d = ST_GRANT0;
        end else if (in1_valid) begin
          state_d = ST_GRANT1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (grantDone) begin
          last_d  = grantIdx;
          count_d = '0;
          if (otherValid) begin
            state_d = grantState(!grantIdx);
          end else if (grantValid) begin
            state_d = state_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (xfer) begin
          count_d = countInc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Arbiter state and the single-entry output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      count_q    <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSrc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
      if (xfer) begin
        outValid_q <= 1'b1;
        outData_q  <= muxData;
        outSrc_q   <= grantIdx;
      end else if (out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign in0_ready = (state_q == ST_GRANT0) && canLoad;
  assign in1_ready = (state_q == ST_GRANT1) && canLoad;
  assign sel       = grantIdx;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_src   = outSrc_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural model of the arbiter.
module tb_mux2_rr_arbiter;

  localparam int W         = 4;
  localparam int MAX_BURST = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in0_valid, in1_valid, out_ready;
  logic [W-1:0] in0_data, in1_data;
  logic         in0_ready, in1_ready, out_valid, out_src, sel, busy;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         src;
  } beat_t;

  // Behavioural model: who owns the channel (-1 = nobody), who won last,
  // beats taken in this grant, and the contents of the output stage.
  int    mOwner;
  int    mLast;
  int    mBeats;
  beat_t mStage[$];
  bit    took0, took1;

  mux2_rr_arbiter #(
    .W         (W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic checkData(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mOwner = -1;
    mLast  = 1;
    mBeats = 0;
    mStage.delete();
  endtask

  // Compare every DUT output with what the model says should be visible now
  task automatic checkOutput(input string tag, input logic ordy);
    bit stageFree;
    stageFree = (mStage.size() == 0) || ordy;
    checkBit({tag, ".busy"}, busy, mOwner >= 0);
    checkBit({tag, ".sel"}, sel, mOwner == 1);
    checkBit({tag, ".in0_ready"}, in0_ready, (mOwner == 0) && stageFree);
    checkBit({tag, ".in1_ready"}, in1_ready, (mOwner == 1) && stageFree);
    checkBit({tag, ".out_valid"}, out_valid, mStage.size() != 0);
    if (mStage.size() != 0) begin
      checkData({tag, ".out_data"}, out_data, mStage[0].data);
      checkBit({tag, ".out_src"}, out_src, mStage[0].src);
    end
  endtask

  // Advance the model by one clock using the arbitration rules
  task automatic modelAdvance(input bit v0, input logic [W-1:0] d0,
                              input bit v1, input logic [W-1:0] d1, input bit ordy);
    bit    stageFree, gv, ov, took;
    int    g;
    beat_t b;
    stageFree = (mStage.size() == 0) || ordy;
    took0 = 0;
    took1 = 0;
    took  = 0;
    g     = mOwner;
    gv    = (g == 0) ? v0 : v1;
    ov    = (g == 0) ? v1 : v0;
    if (g >= 0 && gv && stageFree) begin
      took   = 1;
      b.data = (g == 0) ? d0 : d1;
      b.src  = (g == 1);
      mStage.delete();
      mStage.push_back(b);
      mBeats++;
      took0 = (g == 0);
      took1 = (g == 1);
    end else if (ordy) begin
      mStage.delete();
    end
    if (g < 0) begin
      if (v0 && v1) mOwner = 1 - mLast;
      else if (v0) mOwner = 0;
      else if (v1) mOwner = 1;
    end else if (!gv || (took && mBeats == MAX_BURST)) begin
      mLast  = g;
      mBeats = 0;
      mOwner = ov ? 1 - g : (gv ? g : -1);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check, step model, clock
  task automatic applyStimulus(input string tag, input bit v0, input logic [W-1:0] d0,
                               input bit v1, input logic [W-1:0] d1, input bit ordy);
    in0_valid = v0;
    in0_data  = d0;
    in1_valid = v1;
    in1_data  = d1;
    out_ready = ordy;
    #1;
    checkOutput(tag, ordy);
    modelAdvance(v0, d0, v1, d1, ordy);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int           beatIdx;
    int           steps;
    logic [W-1:0] nextD0;

    // Reset held with both requesters asking
    rst_n     = 1'b0;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 4'hA;
    in1_data  = 4'h5;
    out_ready = 1'b1;
    modelReset();
    #1;
    checkOutput("reset", 1'b1);
    checkData("reset.out_data", out_data, 4'h0);
    checkBit("reset.out_src", out_src, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Both continuously valid: source pattern follows bursts of MAX_BURST
    beatIdx = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) begin
        checkBit("rr_pattern", out_src, ((beatIdx / MAX_BURST) % 2) == 1);
        beatIdx++;
      end
      applyStimulus("both", 1'b1, 4'hA, 1'b1, 4'h5, 1'b1);
    end

    // Requester 0 alone sends 1..6
    nextD0 = 4'h1;
    steps  = 0;
    while (nextD0 <= 4'h6 && steps < 30) begin
      applyStimulus("solo0", 1'b1, nextD0, 1'b0, 4'h0, 1'b1);
      if (took0) nextD0++;
      steps++;
    end
    checkBit("solo0.done", nextD0 == 4'h7, 1'b1);

    // Backpressure for three cycles with a beat held, then release
    for (int i = 0; i < 3; i++) applyStimulus("stall", 1'b1, 4'h7, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("unstall", 1'b1, 4'h8, 1'b0, 4'h0, 1'b1);

    // Go idle, then requester 0 drops after two beats while 1 is waiting
    for (int i = 0; i < 3; i++) applyStimulus("idle", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("drop.pre", 1'b1, 4'h3, 1'b0, 4'h0, 1'b1);
    applyStimulus("drop.switch", 1'b0, 4'h0, 1'b1, 4'hC, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("drop.post", 1'b0, 4'h0, 1'b1, 4'hD, 1'b1);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 3; i++) applyStimulus("preRst", 1'b1, 4'h9, 1'b1, 4'h6, 1'b1);
    checkBit("preRst.out_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkBit("asyncRst.out_valid", out_valid, 1'b0);
    checkBit("asyncRst.in0_ready", in0_ready, 1'b0);
    checkBit("asyncRst.in1_ready", in1_ready, 1'b0);
    checkBit("asyncRst.busy", busy, 1'b0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus("postRst", 1'b1, 4'h2, 1'b1, 4'h4, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    $urandom_range(0, 3) != 0, W'($urandom),
                    $urandom_range(0, 3) != 0, W'($urandom),
                    $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter sharing one W-bit output channel between two valid/ready requesters.
- Drives the select of a W-bit 2:1 mux datapath.
- Registers the selected beat into a single output stage, tagged with its source.
- Holds a grant for a burst of up to MAX_BURST beats, then rotates priority.

Parameters:
- W, 4, data width of each input and of the output.
- MAX_BURST, 4, maximum beats transferred per grant; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in0_valid  input  1  requester 0 has a beat.
- in0_data  input  W  requester 0 beat.
- in0_ready  output  1  requester 0 beat accepted this cycle when in0_valid=1.
- in1_valid  input  1  requester 1 has a beat.
- in1_data  input  W  requester 1 beat.
- in1_ready  output  1  requester 1 beat accepted this cycle when in1_valid=1.
- out_valid  output  1  out_data holds a beat.
- out_data  output  W  registered selected beat.
- out_src  output  1  index of the requester that produced out_data.
- out_ready  input  1  downstream accepts the beat this cycle.
- sel  output  1  current grant index, drives the mux select.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low. Reset forces state=IDLE, priority pointer last=1 (requester 0 wins first), beat count=0, out_valid=0, out_data=0, out_src=0, sel=0. in0_ready, in1_ready and busy are all 0.
- Reset mid-operation: any beat in the output register is discarded. No partial state survives.
- States:
  - IDLE: no grant; both readies 0.
  - GRANT0: requester 0 granted; sel=0.
  - GRANT1: requester 1 granted; sel=1.
- Stage-free condition: can_load = !out_valid || out_ready.
- Readies: inN_ready = (state==GRANTN) && can_load. The non-granted ready is always 0.
- Transfer: happens when the granted requester has valid=1 and ready=1. On transfer, out_data <= granted data (via the mux), out_src <= grant index, out_valid <= 1. The beat count increments.
- Output stage: out_valid clears when out_ready=1 and no transfer occurs that cycle. Simultaneous drain and load keeps out_valid=1 with the new beat, so there is no bubble.
- Output stability: out_data and out_src hold while out_valid=1 and out_ready=0.
- Arbitration in IDLE:
  - Only in0_valid=1 -> GRANT0 next cycle.
  - Only in1_valid=1 -> GRANT1 next cycle.
  - Both valid -> grant index = !last.
  - Neither valid -> stay in IDLE.
- Latency: request seen in IDLE -> grant the next cycle -> first transfer in that grant cycle (if can_load) -> out_valid the cycle after that.
- Release conditions for the grant:
  - The transfer that makes count==MAX_BURST.
  - A cycle in GRANT state where the granted valid=0.
  - Backpressure (valid=1 but can_load=0) does not release the grant and does not increment the count.
- On release:
  - last <= granted index and count <= 0.
  - Next state: GRANT of the other requester if its valid=1 this cycle; else GRANT of the same requester if it is still valid (burst-limit case with no competitor); else IDLE.
- MAX_BURST=1: the grant alternates every beat when both requesters are valid.
- Count width is 4 bits; the count never exceeds MAX_BURST.

Decomposition:
- Shared header holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_GRANT0=2'd1, ST_GRANT1=2'd2; 2'd3 is illegal and recovers to IDLE.
  - the default W and MAX_BURST.
- One sub-module: the existing W-bit 2:1 mux (mux_2to1_4b, instantiated for W=4) selects in0_data/in1_data under sel.
- The FSM, counter and output register stay in this block.

Test Plan:
- Reset with in0_valid=in1_valid=1 -> all outputs 0. First grant is GRANT0 one cycle after rst_n rises. out_valid=1 with out_src=0 the following cycle.
- Requester 0 alone, data 4'h1..4'h6, out_ready=1, MAX_BURST=4 -> six beats out in order, all with out_src=0, no bubble; the grant re-issues to 0 after beat 4.
- Both requesters continuously valid (in0=4'hA, in1=4'h5), out_ready=1 -> out_src pattern 0,0,0,0,1,1,1,1,0,... and sel toggles every 4 beats.
- out_ready=0 for 3 cycles with a beat held -> out_data stable, in*_ready=0, count frozen; on out_ready=1, the next beat loads the same cycle.
- Granted requester drops valid mid-burst after 2 beats while the other is valid -> grant switches to the other the next cycle and last updates.
- Assert rst_n=0 asynchronously mid-burst with out_valid=1 -> out_valid, in*_ready and busy drop immediately (before the next edge); after release the FSM starts from IDLE with requester 0 prioritized.
